// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer
//
// Sits directly downstream of the PLL and runs from its output clock.
// It qualifies the PLL lock, then releases the system reset synchronously
// once lock has been stable, generates the 3.579 MHz bus clock-enable, and
// counts lock losses taken while running.
//
// Optional feature macro: CLOCK_RESET_SEQUENCER_PHASE_EN
//   When defined, adds enable_3m579_n, a clock-enable pulse offset by half a
//   divider period from enable_3m579.
//
// Ports:
//   clk             in   PLL output clock, the only clock
//   n_reset         in   asynchronous active-low reset
//   pll_lock        in   PLL lock, asynchronous to clk
//   soft_reset_req  in   one-cycle request to re-run the reset hold
//   sys_n_reset     out  system reset, active-low, released synchronously
//   enable_3m579    out  one-clk pulse every CLK_DIV cycles
//   enable_3m579_n  out  half-period-offset pulse (macro builds only)
//   lock_loss_count out  saturating count of lock drops taken from run
//   seq_state       out  0 wait-lock, 1 stable, 2 hold, 3 run
module clock_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 64,
  parameter int unsigned CLK_DIV            = 46
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       pll_lock,
  input  logic       soft_reset_req,
  output logic       sys_n_reset,
  output logic       enable_3m579,
`ifdef CLOCK_RESET_SEQUENCER_PHASE_EN
  output logic       enable_3m579_n,
`endif
  output logic [7:0] lock_loss_count,
  output logic [1:0] seq_state
);

  localparam int unsigned StableW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned HoldW   = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [StableW-1:0] StableMax = StableW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0]   HoldMax   = HoldW'(RESET_HOLD_CYCLES - 1);
  localparam logic [DivW-1:0]    DivMax    = DivW'(CLK_DIV - 1);
`ifdef CLOCK_RESET_SEQUENCER_PHASE_EN
  localparam logic [DivW-1:0]    DivHalf   = DivW'(CLK_DIV / 2 - 1);
`endif

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StStable   = 2'd1,
    StHold     = 2'd2,
    StRun      = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               lock_meta_q, lock_s_q;
  logic [StableW-1:0] stable_q, stable_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [7:0]         loss_q, loss_d;
  logic               sys_n_reset_q, sys_n_reset_d;
  logic               enable_q, enable_d;
  logic               div_run_d;
  logic [DivW-1:0]    div_inc;
`ifdef CLOCK_RESET_SEQUENCER_PHASE_EN
  logic               enable_n_q, enable_n_d;
`endif

  assign div_inc = (div_q == DivMax) ? '0 : div_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    stable_d = '0;
    hold_d   = '0;
    div_d    = '0;
    loss_d   = loss_q;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s_q) state_d = StStable;
      end
      StStable: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
        end else if (stable_q == StableMax) begin
          state_d = StHold;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      StHold: begin
        div_d = div_inc;
        if (!lock_s_q) begin
          state_d = StWaitLock;
          div_d   = '0;
        end else if (soft_reset_req) begin
          // Restarts only the hold count; the divider keeps its phase.
          hold_d = '0;
        end else if (hold_q == HoldMax) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun: begin
        div_d = div_inc;
        if (!lock_s_q) begin
          // Lock loss takes priority over a simultaneous soft reset request.
          state_d = StWaitLock;
          div_d   = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (soft_reset_req) begin
          state_d = StHold;
          div_d   = '0;
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so they change on the
  // same edge as the state, with no input-to-output combinational path.
  always_comb begin
    div_run_d     = (state_d == StHold) || (state_d == StRun);
    // Rises one edge after the state becomes run.
    sys_n_reset_d = (state_q == StRun) && (state_d == StRun);
    enable_d      = div_run_d && (div_d == DivMax);
`ifdef CLOCK_RESET_SEQUENCER_PHASE_EN
    enable_n_d    = div_run_d && (div_d == DivHalf);
`endif
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      state_q       <= StWaitLock;
      stable_q      <= '0;
      hold_q        <= '0;
      div_q         <= '0;
      loss_q        <= 8'd0;
      sys_n_reset_q <= 1'b0;
      enable_q      <= 1'b0;
`ifdef CLOCK_RESET_SEQUENCER_PHASE_EN
      enable_n_q    <= 1'b0;
`endif
    end else begin
      lock_meta_q   <= pll_lock;
      lock_s_q      <= lock_meta_q;
      state_q       <= state_d;
      stable_q      <= stable_d;
      hold_q        <= hold_d;
      div_q         <= div_d;
      loss_q        <= loss_d;
      sys_n_reset_q <= sys_n_reset_d;
      enable_q      <= enable_d;
`ifdef CLOCK_RESET_SEQUENCER_PHASE_EN
      enable_n_q    <= enable_n_d;
`endif
    end
  end

  assign sys_n_reset     = sys_n_reset_q;
  assign enable_3m579    = enable_q;
  assign lock_loss_count = loss_q;
  assign seq_state       = state_q;
`ifdef CLOCK_RESET_SEQUENCER_PHASE_EN
  assign enable_3m579_n  = enable_n_q;
`endif

endmodule
